// File: rtl/retire_chk_pkg.sv
// Shared types and constants for the retire-stream checker: FSM states,
// error codes and the retire record layout.
package retire_chk_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } chk_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_EXTRA    = 2'd3;

  localparam int REC_W       = 70;
  localparam int REC_EN      = 69;
  localparam int REC_WADDR_HI = 68;
  localparam int REC_WADDR_LO = 64;
  localparam int REC_WDATA_HI = 63;
  localparam int REC_WDATA_LO = 32;
  localparam int REC_PC_HI    = 31;
  localparam int REC_PC_LO    = 0;

  localparam logic [31:0] DEFAULT_END_ADDR = 32'h0000_000C;

  // A record is worth checking only if it writes a real register.
  function automatic logic rec_kept(input logic [REC_W-1:0] rec);
    return rec[REC_EN] && (rec[REC_WADDR_HI:REC_WADDR_LO] != 5'd0);
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Record FIFO accepting up to W compacted records per cycle and one pop.
// Head is read combinationally so a record pushed at edge t is visible in t+1.
module retire_fifo
  import retire_chk_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  parameter int NW    = $clog2(W + 1),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NW-1:0]        push_n,
  input  logic [W*REC_W-1:0]   push_data,
  input  logic                 pop,
  output logic [REC_W-1:0]     head,
  output logic [CW-1:0]        count
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (i < int'(push_n)) begin
        mem[wr_ptr_reg + AW'(i)] <= push_data[i*REC_W +: REC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_n);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push_n) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/retire_checker.sv
// Compacts multi-lane retire records into a FIFO and checks them in order
// against a golden stream, latching a sticky verdict with first-error snapshot.
module retire_checker
  import retire_chk_pkg::*;
#(
  parameter int          RETIRE_W = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] END_ADDR = DEFAULT_END_ADDR
) (
  input  logic                        sys_clk,
  input  logic                        sys_reset_n,
  input  logic [REC_W*RETIRE_W-1:0]   inst_retire,
  output logic                        rt_stall,
  input  logic                        gold_valid,
  output logic                        gold_ready,
  input  logic [31:0]                 gold_pc,
  input  logic [31:0]                 gold_wdata,
  input  logic [31:0]                 gold_mask,
  input  logic [4:0]                  gold_waddr,
  input  logic                        gold_last,
  input  logic                        mem_wen,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  output logic                        check_pass,
  output logic                        check_fail,
  output logic [1:0]                  err_code,
  output logic [31:0]                 err_pc,
  output logic [31:0]                 err_wdata,
  output logic [31:0]                 err_gold_wdata,
  output logic [4:0]                  err_waddr,
  output logic [31:0]                 cmp_cnt
);

  localparam int NW = $clog2(RETIRE_W + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [REC_W-1:0]          lane_rec [RETIRE_W];
  logic [RETIRE_W-1:0]       keep;
  logic [NW-1:0]             pos [RETIRE_W];
  logic [NW-1:0]             kept_n;
  logic [REC_W*RETIRE_W-1:0] push_data;
  logic [NW-1:0]             push_n;
  logic [REC_W-1:0]          ovf_rec;
  logic [REC_W-1:0]          head;
  logic [CW-1:0]             count;
  logic [CW-1:0]             free;
  logic                      active;
  logic                      overflow;
  logic                      mismatch;
  logic                      end_store;
  logic                      fifo_empty;

  chk_state_e  state_reg, state_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [31:0] err_pc_reg, err_pc_next;
  logic [31:0] err_wdata_reg, err_wdata_next;
  logic [31:0] err_gold_wdata_reg, err_gold_wdata_next;
  logic [4:0]  err_waddr_reg, err_waddr_next;
  logic [31:0] cmp_cnt_reg, cmp_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < RETIRE_W; gi++) begin : g_lane
      assign lane_rec[gi] = inst_retire[gi*REC_W +: REC_W];
      assign keep[gi]     = rec_kept(lane_rec[gi]);
    end
  endgenerate

  // Prefix count gives each kept lane its slot; lane 0 is the oldest.
  always_comb begin
    logic [NW-1:0] acc;
    acc = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      pos[k] = acc;
      if (keep[k]) acc = acc + NW'(1);
    end
    kept_n = acc;
  end

  assign free       = CW'(DEPTH) - count;
  assign fifo_empty = (count == '0);
  assign active     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign overflow   = active && (CW'(kept_n) > free);
  assign rt_stall   = (free < CW'(RETIRE_W));

  always_comb begin
    push_data = '0;
    ovf_rec   = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (keep[k]) begin
        push_data[int'(pos[k])*REC_W +: REC_W] = lane_rec[k];
        // The first lane past the free space is the first one dropped.
        if (CW'(pos[k]) == free) ovf_rec = lane_rec[k];
      end
    end
  end

  always_comb begin
    push_n = '0;
    if (active) push_n = overflow ? NW'(free) : kept_n;
  end

  retire_fifo #(
    .W     (RETIRE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_reset_n),
    .push_n    (push_n),
    .push_data (push_data),
    .pop       (gold_ready),
    .head      (head),
    .count     (count)
  );

  assign gold_ready = (state_reg == ST_RUN) && !fifo_empty && gold_valid;
  assign mismatch   = (head[REC_PC_HI:REC_PC_LO] != gold_pc) ||
                      (head[REC_WADDR_HI:REC_WADDR_LO] != gold_waddr) ||
                      ((head[REC_WDATA_HI:REC_WDATA_LO] & gold_mask) != (gold_wdata & gold_mask));
  assign end_store  = mem_wen && (mem_addr == END_ADDR) && (mem_wdata == 32'd0);

  always_comb begin
    state_next          = state_reg;
    err_code_next       = err_code_reg;
    err_pc_next         = err_pc_reg;
    err_wdata_next      = err_wdata_reg;
    err_gold_wdata_next = err_gold_wdata_reg;
    err_waddr_next      = err_waddr_reg;
    cmp_cnt_next        = cmp_cnt_reg;
    if (overflow) begin
      state_next          = ST_FAIL;
      err_code_next       = ERR_OVERFLOW;
      err_pc_next         = ovf_rec[REC_PC_HI:REC_PC_LO];
      err_wdata_next      = ovf_rec[REC_WDATA_HI:REC_WDATA_LO];
      err_waddr_next      = ovf_rec[REC_WADDR_HI:REC_WADDR_LO];
      err_gold_wdata_next = 32'd0;
    end else if (gold_ready && mismatch) begin
      state_next          = ST_FAIL;
      err_code_next       = ERR_MISMATCH;
      err_pc_next         = head[REC_PC_HI:REC_PC_LO];
      err_wdata_next      = head[REC_WDATA_HI:REC_WDATA_LO];
      err_waddr_next      = head[REC_WADDR_HI:REC_WADDR_LO];
      err_gold_wdata_next = gold_wdata;
    end else if (state_reg == ST_RUN && end_store) begin
      state_next    = ST_FAIL;
      err_code_next = ERR_EXTRA;
    end else if (state_reg == ST_DRAIN && (!fifo_empty || kept_n != '0)) begin
      // Snapshot whichever unexpected record is oldest.
      state_next    = ST_FAIL;
      err_code_next = ERR_EXTRA;
      if (!fifo_empty) begin
        err_pc_next    = head[REC_PC_HI:REC_PC_LO];
        err_wdata_next = head[REC_WDATA_HI:REC_WDATA_LO];
        err_waddr_next = head[REC_WADDR_HI:REC_WADDR_LO];
      end else begin
        err_pc_next    = push_data[REC_PC_HI:REC_PC_LO];
        err_wdata_next = push_data[REC_WDATA_HI:REC_WDATA_LO];
        err_waddr_next = push_data[REC_WADDR_HI:REC_WADDR_LO];
      end
    end else if (state_reg == ST_DRAIN && end_store) begin
      state_next = ST_PASS;
    end else if (gold_ready) begin
      cmp_cnt_next = cmp_cnt_reg + 32'd1;
      if (gold_last) state_next = ST_DRAIN;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_reg          <= ST_RUN;
      err_code_reg       <= ERR_NONE;
      err_pc_reg         <= '0;
      err_wdata_reg      <= '0;
      err_gold_wdata_reg <= '0;
      err_waddr_reg      <= '0;
      cmp_cnt_reg        <= '0;
    end else begin
      state_reg          <= state_next;
      err_code_reg       <= err_code_next;
      err_pc_reg         <= err_pc_next;
      err_wdata_reg      <= err_wdata_next;
      err_gold_wdata_reg <= err_gold_wdata_next;
      err_waddr_reg      <= err_waddr_next;
      cmp_cnt_reg        <= cmp_cnt_next;
    end
  end

  assign check_pass     = (state_reg == ST_PASS);
  assign check_fail     = (state_reg == ST_FAIL);
  assign err_code       = err_code_reg;
  assign err_pc         = err_pc_reg;
  assign err_wdata      = err_wdata_reg;
  assign err_gold_wdata = err_gold_wdata_reg;
  assign err_waddr      = err_waddr_reg;
  assign cmp_cnt        = cmp_cnt_reg;

endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker (RETIRE_W=2, DEPTH=4) with hand-computed expectations.
module tb_retire_checker;

  logic         sys_clk;
  logic         sys_reset_n;
  logic [139:0] inst_retire;
  logic         rt_stall;
  logic         gold_valid;
  logic         gold_ready;
  logic [31:0]  gold_pc, gold_wdata, gold_mask;
  logic [4:0]   gold_waddr;
  logic         gold_last;
  logic         mem_wen;
  logic [31:0]  mem_addr, mem_wdata;
  logic         check_pass, check_fail;
  logic [1:0]   err_code;
  logic [31:0]  err_pc, err_wdata, err_gold_wdata;
  logic [4:0]   err_waddr;
  logic [31:0]  cmp_cnt;

  int total = 0;
  int bad   = 0;

  retire_checker #(
    .RETIRE_W (2),
    .DEPTH    (4),
    .END_ADDR (32'h0000_000C)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_reset_n    (sys_reset_n),
    .inst_retire    (inst_retire),
    .rt_stall       (rt_stall),
    .gold_valid     (gold_valid),
    .gold_ready     (gold_ready),
    .gold_pc        (gold_pc),
    .gold_wdata     (gold_wdata),
    .gold_mask      (gold_mask),
    .gold_waddr     (gold_waddr),
    .gold_last      (gold_last),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .check_pass     (check_pass),
    .check_fail     (check_fail),
    .err_code       (err_code),
    .err_pc         (err_pc),
    .err_wdata      (err_wdata),
    .err_gold_wdata (err_gold_wdata),
    .err_waddr      (err_waddr),
    .cmp_cnt        (cmp_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [69:0] mk(input logic en, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic [31:0] pc);
    return {en, wa, wd, pc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    inst_retire = '0;
    gold_valid  = 1'b0;
    gold_pc     = '0;
    gold_wdata  = '0;
    gold_mask   = 32'hFFFF_FFFF;
    gold_waddr  = '0;
    gold_last   = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
  endtask

  task automatic do_reset();
    idle();
    sys_reset_n = 1'b0;
    tick();
    tick();
    sys_reset_n = 1'b1;
    tick();
  endtask

  task automatic gold(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] mask, input logic last);
    gold_valid = 1'b1;
    gold_pc    = pc;
    gold_waddr = wa;
    gold_wdata = wd;
    gold_mask  = mask;
    gold_last  = last;
  endtask

  initial begin
    sys_reset_n = 1'b0;
    idle();
    #1;
    chk("async_reset_fail", {31'd0, check_fail}, 32'd0);
    do_reset();

    // Reset state
    chk("rst_pass", {31'd0, check_pass}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_cmp", cmp_cnt, 32'd0);
    chk("rst_stall", {31'd0, rt_stall}, 32'd0);

    // Two-record run ending in PASS
    inst_retire = {mk(1'b1, 5'd6, 32'h22, 32'h104), mk(1'b1, 5'd5, 32'h11, 32'h100)};
    tick();
    inst_retire = '0;
    gold(32'h100, 5'd5, 32'h11, 32'hFFFF_FFFF, 1'b0);
    #1;
    chk("t1_ready", {31'd0, gold_ready}, 32'd1);
    tick();
    gold(32'h104, 5'd6, 32'h22, 32'hFFFF_FFFF, 1'b1);
    tick();
    gold_valid = 1'b0;
    chk("t1_cmp", cmp_cnt, 32'd2);
    chk("t1_nopass_yet", {31'd0, check_pass}, 32'd0);
    mem_wen = 1'b1; mem_addr = 32'h0C; mem_wdata = 32'd0;
    tick();
    mem_wen = 1'b0;
    chk("t1_pass", {31'd0, check_pass}, 32'd1);
    chk("t1_fail", {31'd0, check_fail}, 32'd0);
    chk("t1_code", {30'd0, err_code}, 32'd0);

    // x0 lane filtered out
    do_reset();
    inst_retire = {mk(1'b1, 5'd7, 32'h5, 32'h204), mk(1'b1, 5'd0, 32'h99, 32'h200)};
    tick();
    inst_retire = '0;
    gold(32'h204, 5'd7, 32'h5, 32'hFFFF_FFFF, 1'b0);
    #1;
    chk("t2_ready_first", {31'd0, gold_ready}, 32'd1);
    tick();
    chk("t2_ready_second", {31'd0, gold_ready}, 32'd0);
    chk("t2_cmp", cmp_cnt, 32'd1);
    chk("t2_fail", {31'd0, check_fail}, 32'd0);

    // Masked compare, then full-mask mismatch
    do_reset();
    inst_retire = {mk(1'b1, 5'd10, 32'h1, 32'h304), mk(1'b1, 5'd9, 32'h1, 32'h300)};
    tick();
    inst_retire = '0;
    gold(32'h300, 5'd9, 32'hFFFF_0001, 32'h0000_FFFF, 1'b0);
    tick();
    chk("t3_mask_cmp", cmp_cnt, 32'd1);
    chk("t3_mask_fail", {31'd0, check_fail}, 32'd0);
    gold(32'h304, 5'd10, 32'hFFFF_0001, 32'hFFFF_FFFF, 1'b0);
    tick();
    gold_valid = 1'b0;
    chk("t3_fail", {31'd0, check_fail}, 32'd1);
    chk("t3_code", {30'd0, err_code}, 32'd1);
    chk("t3_err_pc", err_pc, 32'h304);
    chk("t3_err_wdata", err_wdata, 32'h1);
    chk("t3_err_gold", err_gold_wdata, 32'hFFFF_0001);
    chk("t3_err_waddr", {27'd0, err_waddr}, 32'd10);
    chk("t3_cmp_hold", cmp_cnt, 32'd1);

    // Overflow with DEPTH=4
    do_reset();
    inst_retire = {mk(1'b1, 5'd2, 32'h2, 32'h404), mk(1'b1, 5'd1, 32'h1, 32'h400)};
    tick();
    chk("t4_stall_c1", {31'd0, rt_stall}, 32'd0);
    inst_retire = {mk(1'b1, 5'd4, 32'h4, 32'h40C), mk(1'b1, 5'd3, 32'h3, 32'h408)};
    tick();
    chk("t4_stall_c2", {31'd0, rt_stall}, 32'd1);
    inst_retire = {mk(1'b1, 5'd12, 32'hBB, 32'h414), mk(1'b1, 5'd11, 32'hAA, 32'h410)};
    tick();
    inst_retire = '0;
    chk("t4_fail", {31'd0, check_fail}, 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd2);
    chk("t4_err_pc", err_pc, 32'h410);
    chk("t4_err_waddr", {27'd0, err_waddr}, 32'd11);
    chk("t4_err_wdata", err_wdata, 32'hAA);
    chk("t4_err_gold", err_gold_wdata, 32'd0);

    // Early end store
    do_reset();
    mem_wen = 1'b1; mem_addr = 32'h0C; mem_wdata = 32'd0;
    tick();
    mem_wen = 1'b0;
    chk("t5_early_code", {30'd0, err_code}, 32'd3);
    chk("t5_early_pass", {31'd0, check_pass}, 32'd0);

    // Extra retire after the last golden record
    do_reset();
    inst_retire = {mk(1'b0, 5'd0, 32'h0, 32'h0), mk(1'b1, 5'd5, 32'h55, 32'h500)};
    tick();
    inst_retire = '0;
    gold(32'h500, 5'd5, 32'h55, 32'hFFFF_FFFF, 1'b1);
    tick();
    gold_valid = 1'b0;
    chk("t5_drain_fail", {31'd0, check_fail}, 32'd0);
    inst_retire = {mk(1'b0, 5'd0, 32'h0, 32'h0), mk(1'b1, 5'd3, 32'h33, 32'h504)};
    tick();
    inst_retire = '0;
    chk("t5_extra_code", {30'd0, err_code}, 32'd3);
    chk("t5_extra_fail", {31'd0, check_fail}, 32'd1);

    // Reset while draining
    do_reset();
    inst_retire = {mk(1'b0, 5'd0, 32'h0, 32'h0), mk(1'b1, 5'd5, 32'h55, 32'h600)};
    tick();
    inst_retire = '0;
    gold(32'h600, 5'd5, 32'h55, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle();
    chk("t6_pre_cmp", cmp_cnt, 32'd1);
    sys_reset_n = 1'b0;
    tick();
    chk("t6_rst_cmp", cmp_cnt, 32'd0);
    chk("t6_rst_code", {30'd0, err_code}, 32'd0);
    chk("t6_rst_fail", {31'd0, check_fail}, 32'd0);
    sys_reset_n = 1'b1;
    tick();
    gold_valid = 1'b1;
    #1;
    chk("t6_empty_ready", {31'd0, gold_ready}, 32'd0);
    gold_valid = 1'b0;
    mem_wen = 1'b1; mem_addr = 32'h0C; mem_wdata = 32'd0;
    tick();
    mem_wen = 1'b0;
    chk("t6_run_early_code", {30'd0, err_code}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
